// File: rtl/calc_pkg.sv
// Shared calculator definitions: opcodes, sequencer state encoding and default operand width.
// Opcodes are common to the complement stage, this ALU and the display encoder.
package calc_pkg;

  localparam int CALC_WIDTH = 4;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_DIV = 4'b0100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } calc_state_t;

  function automatic logic is_valid_op(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic is_iter_op(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/calc_alu_seq_if.sv
// Operand/result bundle between the complement stage (master) and the ALU (slave).
// No backpressure: the master strobes start; the ALU drops requests while busy.
interface calc_alu_seq_if import calc_pkg::*; #(
  parameter int WIDTH = CALC_WIDTH
);
  logic                      start;
  logic signed [WIDTH-1:0]   first_nr;
  logic signed [WIDTH-1:0]   second_nr;
  logic [3:0]                operation;
  logic                      busy;
  logic                      done;
  logic signed [2*WIDTH-1:0] result;
  logic signed [WIDTH-1:0]   remainder;
  logic                      error;

  modport master (
    output start, first_nr, second_nr, operation,
    input  busy, done, result, remainder, error
  );

  modport slave (
    input  start, first_nr, second_nr, operation,
    output busy, done, result, remainder, error
  );
endinterface

// File: rtl/calc_magnitude_iter.sv
// Unsigned magnitude engine: shift-add multiply or restoring divide, one bit per step.
// Latency WIDTH steps after load; the caller sequences load/step, there is no backpressure.
module calc_magnitude_iter #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic               i_step,
  input  logic               i_is_div,
  input  logic [WIDTH-1:0]   i_a_mag,
  input  logic [WIDTH-1:0]   i_b_mag,
  output logic               o_last,
  output logic [2*WIDTH-1:0] o_prod,
  output logic [WIDTH-1:0]   o_quot,
  output logic [WIDTH-1:0]   o_rem
);
  localparam int CW = $clog2(WIDTH + 1);

  // r_acc is the product high half for mul and the partial remainder for div.
  logic [WIDTH:0]   r_acc;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_m;
  logic [CW-1:0]    r_cnt;
  logic             r_div;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_dshift;
  logic [WIDTH+1:0] w_trial;
  logic             w_neg;

  assign w_sum    = r_acc + (r_lo[0] ? {1'b0, r_m} : '0);
  assign w_dshift = {r_acc[WIDTH-1:0], r_lo[WIDTH-1]};
  assign w_trial  = {1'b0, w_dshift} - {2'b00, r_m};
  assign w_neg    = w_trial[WIDTH+1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_lo  <= '0;
      r_m   <= '0;
      r_cnt <= '0;
      r_div <= 1'b0;
    end else if (i_load) begin
      r_acc <= '0;
      r_lo  <= i_is_div ? i_a_mag : i_b_mag;
      r_m   <= i_is_div ? i_b_mag : i_a_mag;
      r_cnt <= CW'(WIDTH);
      r_div <= i_is_div;
    end else if (i_step) begin
      if (r_div) begin
        r_acc <= w_neg ? w_dshift : w_trial[WIDTH:0];
        r_lo  <= {r_lo[WIDTH-2:0], ~w_neg};
      end else begin
        {r_acc, r_lo} <= {1'b0, w_sum, r_lo[WIDTH-1:1]};
      end
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_last = (r_cnt == CW'(1));
  assign o_prod = {r_acc[WIDTH-1:0], r_lo};
  assign o_quot = r_lo;
  assign o_rem  = r_acc[WIDTH-1:0];

endmodule

// File: rtl/calc_alu_seq.sv
// Sequential ALU: add/sub in 2 cycles, mul/div in WIDTH+2 cycles from start to done pulse.
// Starts arriving while busy are dropped; a start during the done cycle is accepted.
module calc_alu_seq import calc_pkg::*; #(
  parameter int WIDTH = CALC_WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  calc_alu_seq_if.slave  bus
);
  localparam int RW = 2 * WIDTH;

  calc_state_t r_state, w_next;

  logic [WIDTH-1:0] r_a, r_b;
  logic [3:0]       r_op;
  logic             r_sign;
  logic [RW-1:0]    r_result;
  logic [WIDTH-1:0] r_rem;
  logic             r_error;

  logic             w_accept, w_fail, w_is_iter, w_step, w_last;
  logic             w_busy, w_done;
  logic [WIDTH-1:0] w_a_mag, w_b_mag, w_quot, w_rem_mag;
  logic [RW-1:0]    w_prod, w_quot_ext, w_a_ext, w_b_ext;

  assign w_accept  = bus.start && ((r_state == IDLE) || (r_state == DONE));
  assign w_a_mag   = bus.first_nr[WIDTH-1]  ? WIDTH'(-bus.first_nr)  : bus.first_nr;
  assign w_b_mag   = bus.second_nr[WIDTH-1] ? WIDTH'(-bus.second_nr) : bus.second_nr;
  assign w_is_iter = is_iter_op(r_op);
  assign w_fail    = !is_valid_op(r_op) || ((r_op == OP_DIV) && (r_b == '0));
  assign w_step    = (r_state == EXEC) && w_is_iter && !w_fail;
  assign w_a_ext   = {{WIDTH{r_a[WIDTH-1]}}, r_a};
  assign w_b_ext   = {{WIDTH{r_b[WIDTH-1]}}, r_b};
  assign w_quot_ext = {{WIDTH{1'b0}}, w_quot};

  calc_magnitude_iter #(.WIDTH(WIDTH)) u_iter (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_accept),
    .i_step   (w_step),
    .i_is_div (bus.operation == OP_DIV),
    .i_a_mag  (w_a_mag),
    .i_b_mag  (w_b_mag),
    .o_last   (w_last),
    .o_prod   (w_prod),
    .o_quot   (w_quot),
    .o_rem    (w_rem_mag)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (bus.start) w_next = EXEC;
      EXEC: begin
        if (!w_is_iter || w_fail) w_next = DONE;
        else if (w_last)          w_next = FIX;
      end
      FIX:  w_next = DONE;
      DONE: w_next = bus.start ? EXEC : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      EXEC, FIX: w_busy = 1'b1;
      DONE:      w_done = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_sign   <= 1'b0;
      r_result <= '0;
      r_rem    <= '0;
      r_error  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a     <= bus.first_nr;
        r_b     <= bus.second_nr;
        r_op    <= bus.operation;
        r_sign  <= bus.first_nr[WIDTH-1] ^ bus.second_nr[WIDTH-1];
        r_error <= 1'b0;
      end
      if (r_state == EXEC) begin
        if (w_fail) begin
          r_result <= '0;
          r_rem    <= '0;
          r_error  <= 1'b1;
        end else if (r_op == OP_ADD) begin
          r_result <= w_a_ext + w_b_ext;
          r_rem    <= '0;
        end else if (r_op == OP_SUB) begin
          r_result <= w_a_ext - w_b_ext;
          r_rem    <= '0;
        end
      end
      // Truncating division: remainder follows the dividend's sign.
      if (r_state == FIX) begin
        if (r_op == OP_MUL) begin
          r_result <= r_sign ? -w_prod : w_prod;
          r_rem    <= '0;
        end else begin
          r_result <= r_sign ? -w_quot_ext : w_quot_ext;
          r_rem    <= r_a[WIDTH-1] ? -w_rem_mag : w_rem_mag;
        end
      end
    end
  end

  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
  assign bus.result    = r_result;
  assign bus.remainder = r_rem;
  assign bus.error     = r_error;

endmodule

// File: tb/tb_calc_alu_seq.sv
// Directed bench for calc_alu_seq at WIDTH=4 with hand-computed results and latencies.
module tb_calc_alu_seq;
  import calc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  calc_alu_seq_if #(.WIDTH(4)) bus ();

  calc_alu_seq #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called on a falling edge; inj > 0 pulses a competing add start in that busy cycle.
  task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] op, input int exp_lat, input logic [7:0] exp_res,
                        input logic [3:0] exp_rem, input logic exp_err, input int inj);
    int lat;
    bus.first_nr  = a;
    bus.second_nr = b;
    bus.operation = op;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    while (!bus.done && lat < 40) begin
      if (lat == inj) begin
        bus.first_nr  = 4'd1;
        bus.second_nr = 4'd1;
        bus.operation = OP_ADD;
        bus.start     = 1'b1;
      end
      @(negedge clk);
      bus.start = 1'b0;
      lat++;
    end
    chk({tag, "_lat"},    32'(lat), 32'(exp_lat));
    chk({tag, "_result"}, 32'($unsigned(bus.result)), 32'(exp_res));
    chk({tag, "_rem"},    32'($unsigned(bus.remainder)), 32'(exp_rem));
    chk({tag, "_err"},    32'(bus.error), 32'(exp_err));
    chk({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk({tag, "_pulse"},  32'(bus.done), 32'd0);
    chk({tag, "_hold"},   32'($unsigned(bus.result)), 32'(exp_res));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen_done;
    bus.start     = 1'b0;
    bus.first_nr  = '0;
    bus.second_nr = '0;
    bus.operation = '0;

    @(negedge clk);
    chk("rst_busy",   32'(bus.busy), 32'd0);
    chk("rst_done",   32'(bus.done), 32'd0);
    chk("rst_result", 32'($unsigned(bus.result)), 32'd0);
    chk("rst_rem",    32'($unsigned(bus.remainder)), 32'd0);
    chk("rst_err",    32'(bus.error), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    //      tag       A      B      op      lat res    rem   err inj
    run_op("add",    4'd3,  4'd4,  OP_ADD, 2, 8'h07, 4'h0, 0, 0);
    run_op("add_mx", 4'd7,  4'd7,  OP_ADD, 2, 8'h0E, 4'h0, 0, 0);
    run_op("sub",    4'd3,  4'd7,  OP_SUB, 2, 8'hFC, 4'h0, 0, 0);
    run_op("sub_mn", 4'h8,  4'd7,  OP_SUB, 2, 8'hF1, 4'h0, 0, 0);
    run_op("mul",    4'hD,  4'd5,  OP_MUL, 6, 8'hF1, 4'h0, 0, 0);
    run_op("mul_nn", 4'h8,  4'h8,  OP_MUL, 6, 8'h40, 4'h0, 0, 0);
    run_op("mul_pn", 4'd7,  4'h8,  OP_MUL, 6, 8'hC8, 4'h0, 0, 0);
    run_op("div",    4'h9,  4'd2,  OP_DIV, 6, 8'hFD, 4'hF, 0, 0);
    run_op("div_pn", 4'd7,  4'hE,  OP_DIV, 6, 8'hFD, 4'h1, 0, 0);
    run_op("div_nn", 4'h9,  4'hE,  OP_DIV, 6, 8'h03, 4'hF, 0, 0);
    run_op("div_pp", 4'd7,  4'd3,  OP_DIV, 6, 8'h02, 4'h1, 0, 0);
    run_op("div_m1", 4'h8,  4'hF,  OP_DIV, 6, 8'h08, 4'h0, 0, 0);
    run_op("div0",   4'd5,  4'd0,  OP_DIV, 2, 8'h00, 4'h0, 1, 0);
    run_op("badop",  4'd5,  4'd2,  4'b0111, 2, 8'h00, 4'h0, 1, 0);
    run_op("add_clr", 4'd1, 4'd1,  OP_ADD, 2, 8'h02, 4'h0, 0, 0);
    run_op("mul_ign", 4'd3, 4'd5,  OP_MUL, 6, 8'h0F, 4'h0, 0, 3);

    // A start presented during the done cycle is taken at that edge.
    bus.first_nr = 4'd1; bus.second_nr = 4'd2; bus.operation = OP_ADD; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    chk("b2b_done1", 32'(bus.done), 32'd1);
    chk("b2b_res1",  32'($unsigned(bus.result)), 32'h03);
    bus.first_nr = 4'd6; bus.second_nr = 4'd1; bus.operation = OP_SUB; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b_busy",  32'(bus.busy), 32'd1);
    chk("b2b_done0", 32'(bus.done), 32'd0);
    @(negedge clk);
    chk("b2b_done2", 32'(bus.done), 32'd1);
    chk("b2b_res2",  32'($unsigned(bus.result)), 32'h05);
    @(negedge clk);

    // Reset during a multiply aborts it with no done pulse.
    bus.first_nr = 4'd3; bus.second_nr = 4'd3; bus.operation = OP_MUL; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy",   32'(bus.busy), 32'd0);
    chk("abort_done",   32'(bus.done), 32'd0);
    chk("abort_result", 32'($unsigned(bus.result)), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done) seen_done = 1'b1;
    end
    chk("abort_nodone", 32'(seen_done), 32'd0);
    run_op("post_rst", 4'd2, 4'd2, OP_ADD, 2, 8'h04, 4'h0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
